// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the hazard controller.
//   regbits_t      : 5-bit architectural register index
//   REG_ZERO       : hard-wired zero register ($0)
//   hazard_state_t : pipeline control FSM states
package cpu_types_pkg;

  localparam int unsigned REG_W = 5;

  typedef logic [REG_W-1:0] regbits_t;

  localparam regbits_t REG_ZERO = '0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } hazard_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector (purely combinational).
// Ports:
//   dREN_ex   in  load instruction in EX
//   wsel_ex   in  destination register of the EX instruction
//   rs_dec    in  first source register of the DEC instruction
//   rt_dec    in  second source register of the DEC instruction
//   lu_hazard out DEC must wait one cycle for the EX load result
module hazard_detect
  import cpu_types_pkg::*;
(
  input  logic     dREN_ex,
  input  regbits_t wsel_ex,
  input  regbits_t rs_dec,
  input  regbits_t rt_dec,
  output logic     lu_hazard
);

  logic w_src_match;

  assign w_src_match = (wsel_ex == rs_dec) || (wsel_ex == rt_dec);

  // $0 is never written, so a load targeting it cannot create a dependency
  assign lu_hazard = dREN_ex && (wsel_ex != REG_ZERO) && w_src_match;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline hazard controller: memory-wait stalls, taken-branch
// flushes, load-use stalls, fetch-miss bubbles and halt.
// Outputs are combinational from the registered state and current inputs.
// Optional feature macro: PIPE_PERF_EN adds the saturating stall_cycles counter.
// Ports:
//   CLK, nRST             clock, synchronous active-low reset
//   ihit, dhit            fetch / data access completes this cycle
//   dREN_mem, dWEN_mem    data read / write pending in MEM
//   dREN_ex, wsel_ex      load in EX and its destination register
//   rs_dec, rt_dec        DEC source registers
//   branch_taken_mem      taken branch/jump resolved in MEM
//   halt_wb               halt instruction in WB
//   pc_en, en_fd..en_mw   PC and stage-register enables
//   flush_fd..flush_em    stage-register clears to bubble
//   halted                core stopped
//   stall_cycles          cycles with PC held outside HALT (PIPE_PERF_EN only)
module pipeline_hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic     CLK,
  input  logic     nRST,
  input  logic     ihit,
  input  logic     dhit,
  input  logic     dREN_mem,
  input  logic     dWEN_mem,
  input  logic     dREN_ex,
  input  regbits_t wsel_ex,
  input  regbits_t rs_dec,
  input  regbits_t rt_dec,
  input  logic     branch_taken_mem,
  input  logic     halt_wb,
  output logic     pc_en,
  output logic     en_fd,
  output logic     en_de,
  output logic     en_em,
  output logic     en_mw,
  output logic     flush_fd,
  output logic     flush_de,
  output logic     flush_em,
  output logic     halted
`ifdef PIPE_PERF_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cycles
`endif
);

  if (STALL_CNT_W < 1) begin : g_bad_width
    $error("STALL_CNT_W must be at least 1");
  end

  hazard_state_t r_state;
  hazard_state_t w_state_next;
  logic          w_lu_hazard;
  logic          w_mem_busy;

  hazard_detect u_hazard_detect (
    .dREN_ex   (dREN_ex),
    .wsel_ex   (wsel_ex),
    .rs_dec    (rs_dec),
    .rt_dec    (rt_dec),
    .lu_hazard (w_lu_hazard)
  );

  assign w_mem_busy = (dREN_mem || dWEN_mem) && !dhit;

  // State register
  always_ff @(posedge CLK) begin
    if (!nRST) r_state <= RUN;
    else       r_state <= w_state_next;
  end

  // Next state and control outputs
  always_comb begin
    w_state_next = r_state;
    pc_en        = 1'b0;
    en_fd        = 1'b0;
    en_de        = 1'b0;
    en_em        = 1'b0;
    en_mw        = 1'b0;
    flush_fd     = 1'b0;
    flush_de     = 1'b0;
    flush_em     = 1'b0;
    halted       = 1'b0;

    if (!nRST) begin
      // Hold the pipeline as bubbles while reset is asserted
      w_state_next = RUN;
      flush_fd     = 1'b1;
      flush_de     = 1'b1;
      flush_em     = 1'b1;
    end else begin
      case (r_state)
        HALT: begin
          halted = 1'b1;
        end
        default: begin
          if (w_mem_busy) begin
            // Freeze everything; a pending branch is held until dhit
            w_state_next = MEM_WAIT;
          end else begin
            w_state_next = halt_wb ? HALT : RUN;
            if (branch_taken_mem) begin
              pc_en    = 1'b1;
              en_fd    = 1'b1;
              en_de    = 1'b1;
              en_em    = 1'b1;
              en_mw    = 1'b1;
              flush_fd = 1'b1;
              flush_de = 1'b1;
              flush_em = 1'b1;
            end else if (w_lu_hazard) begin
              en_de    = 1'b1;
              en_em    = 1'b1;
              en_mw    = 1'b1;
              flush_de = 1'b1;
            end else if (!ihit) begin
              en_fd    = 1'b1;
              en_de    = 1'b1;
              en_em    = 1'b1;
              en_mw    = 1'b1;
              flush_fd = 1'b1;
            end else begin
              pc_en    = 1'b1;
              en_fd    = 1'b1;
              en_de    = 1'b1;
              en_em    = 1'b1;
              en_mw    = 1'b1;
            end
          end
        end
      endcase
    end
  end

`ifdef PIPE_PERF_EN
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  // Saturating count of cycles with the PC held, excluding HALT
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_stall_cnt <= '0;
    end else if (!pc_en && (r_state != HALT) &&
                 (r_stall_cnt != {STALL_CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
    end
  end

  assign stall_cycles = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl. Expected output vectors are
// pushed to a scoreboard queue as stimulus is applied and popped when the
// outputs are sampled mid-cycle. Define PIPE_PERF_EN to also check the counter.
module tb_pipeline_hazard_ctrl;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       ihit, dhit, dREN_mem, dWEN_mem, dREN_ex;
  logic [4:0] wsel_ex, rs_dec, rt_dec;
  logic       branch_taken_mem, halt_wb;
  logic       pc_en, en_fd, en_de, en_em, en_mw;
  logic       flush_fd, flush_de, flush_em, halted;
`ifdef PIPE_PERF_EN
  logic [3:0] stall_cycles;
`endif

  int errors = 0;
  int checks = 0;
  logic [8:0] exp_q[$];

  // {pc_en, en_fd, en_de, en_em, en_mw, flush_fd, flush_de, flush_em, halted}
  localparam logic [8:0] V_NORMAL = 9'b1_1111_000_0;
  localparam logic [8:0] V_FMISS  = 9'b0_1111_100_0;
  localparam logic [8:0] V_LU     = 9'b0_0111_010_0;
  localparam logic [8:0] V_BR     = 9'b1_1111_111_0;
  localparam logic [8:0] V_STALL  = 9'b0_0000_000_0;
  localparam logic [8:0] V_HALT   = 9'b0_0000_000_1;
  localparam logic [8:0] V_RST    = 9'b0_0000_111_0;

  always #5 CLK = ~CLK;

`ifdef PIPE_PERF_EN
  pipeline_hazard_ctrl #(.STALL_CNT_W(4)) dut (
`else
  pipeline_hazard_ctrl dut (
`endif
    .CLK              (CLK),
    .nRST             (nRST),
    .ihit             (ihit),
    .dhit             (dhit),
    .dREN_mem         (dREN_mem),
    .dWEN_mem         (dWEN_mem),
    .dREN_ex          (dREN_ex),
    .wsel_ex          (wsel_ex),
    .rs_dec           (rs_dec),
    .rt_dec           (rt_dec),
    .branch_taken_mem (branch_taken_mem),
    .halt_wb          (halt_wb),
    .pc_en            (pc_en),
    .en_fd            (en_fd),
    .en_de            (en_de),
    .en_em            (en_em),
    .en_mw            (en_mw),
    .flush_fd         (flush_fd),
    .flush_de         (flush_de),
    .flush_em         (flush_em),
    .halted           (halted)
`ifdef PIPE_PERF_EN
    ,
    .stall_cycles     (stall_cycles)
`endif
  );

  function automatic logic [8:0] outs();
    return {pc_en, en_fd, en_de, en_em, en_mw, flush_fd, flush_de, flush_em, halted};
  endfunction

  // Apply one cycle's inputs (called just after a rising edge)
  task automatic drive(input logic ih, input logic dh, input logic drm, input logic dwm,
                       input logic dre, input logic [4:0] ws, input logic [4:0] rs,
                       input logic [4:0] rt, input logic br, input logic hw);
    ihit = ih; dhit = dh; dREN_mem = drm; dWEN_mem = dwm; dREN_ex = dre;
    wsel_ex = ws; rs_dec = rs; rt_dec = rt; branch_taken_mem = br; halt_wb = hw;
  endtask

  task automatic idle();
    drive(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    logic [8:0] e;
    nRST = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) idle();
      else        drive(0, 0, 1, 0, 1, 5'd3, 5'd3, 5'd0, 1, 1);
      exp_q.push_back(V_RST);
      #4;
      e = exp_q.pop_front();
      checks++;
      if (outs() !== e) begin
        errors++;
        $display("FAIL reset[%0d]: got %b want %b", i, outs(), e);
      end
      tick();
    end
    nRST = 1'b1;
    idle();
    exp_q.push_back(V_NORMAL);
    #4;
    e = exp_q.pop_front();
    checks++;
    if (outs() !== e) begin
      errors++;
      $display("FAIL reset_release: got %b want %b", outs(), e);
    end
    tick();
  endtask

  task automatic test_load_use();
    logic [8:0] e;
    for (int i = 0; i < 7; i++) begin
      case (i)
        0: begin drive(1, 0, 0, 0, 1, 5'd5, 5'd0, 5'd5, 0, 0); exp_q.push_back(V_LU);     end
        1: begin drive(1, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0, 0); exp_q.push_back(V_NORMAL); end
        2: begin drive(1, 0, 0, 0, 1, 5'd7, 5'd7, 5'd1, 0, 0); exp_q.push_back(V_LU);     end
        3: begin drive(1, 0, 0, 0, 0, 5'd7, 5'd7, 5'd7, 0, 0); exp_q.push_back(V_NORMAL); end
        4: begin drive(0, 0, 0, 0, 1, 5'd9, 5'd9, 5'd2, 0, 0); exp_q.push_back(V_LU);     end
        5: begin drive(0, 0, 0, 0, 1, 5'd9, 5'd1, 5'd2, 0, 0); exp_q.push_back(V_FMISS);  end
        default: begin drive(1, 0, 0, 0, 1, 5'd31, 5'd30, 5'd31, 0, 0); exp_q.push_back(V_LU); end
      endcase
      #4;
      e = exp_q.pop_front();
      checks++;
      if (outs() !== e) begin
        errors++;
        $display("FAIL load_use[%0d]: got %b want %b", i, outs(), e);
      end
      tick();
    end
  endtask

  task automatic test_mem_wait();
    logic [8:0] e;
    for (int i = 0; i < 5; i++) begin
      if (i < 3)       begin drive(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0); exp_q.push_back(V_STALL);  end
      else if (i == 3) begin drive(1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0); exp_q.push_back(V_NORMAL); end
      else             begin drive(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0); exp_q.push_back(V_FMISS);  end
      #4;
      e = exp_q.pop_front();
      checks++;
      if (outs() !== e) begin
        errors++;
        $display("FAIL mem_wait[%0d]: got %b want %b", i, outs(), e);
      end
      tick();
    end
  endtask

  task automatic test_branch_in_wait();
    logic [8:0] e;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: begin drive(1, 0, 0, 1, 1, 5'd4, 5'd4, 5'd0, 1, 0); exp_q.push_back(V_STALL); end
        1: begin drive(1, 0, 0, 1, 1, 5'd4, 5'd4, 5'd0, 1, 0); exp_q.push_back(V_STALL); end
        2: begin drive(1, 1, 0, 1, 1, 5'd4, 5'd4, 5'd0, 1, 0); exp_q.push_back(V_BR);    end
        default: begin idle(); exp_q.push_back(V_NORMAL); end
      endcase
      #4;
      e = exp_q.pop_front();
      checks++;
      if (outs() !== e) begin
        errors++;
        $display("FAIL branch_wait[%0d]: got %b want %b", i, outs(), e);
      end
      tick();
    end
  endtask

  task automatic test_branch_priority();
    logic [8:0] e;
    drive(0, 0, 0, 0, 1, 5'd6, 5'd6, 5'd6, 1, 0);
    exp_q.push_back(V_BR);
    #4;
    e = exp_q.pop_front();
    checks++;
    if (outs() !== e) begin
      errors++;
      $display("FAIL branch_vs_lu: got %b want %b", outs(), e);
    end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    logic [8:0] e;
    for (int i = 0; i < 3; i++) begin
      if (i == 0)      begin drive(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0); exp_q.push_back(V_STALL); end
      else if (i == 1) begin nRST = 1'b0; exp_q.push_back(V_RST); end
      else             begin nRST = 1'b1; idle(); exp_q.push_back(V_NORMAL); end
      #4;
      e = exp_q.pop_front();
      checks++;
      if (outs() !== e) begin
        errors++;
        $display("FAIL reset_mid_wait[%0d]: got %b want %b", i, outs(), e);
      end
      tick();
    end
  endtask

  task automatic test_halt();
    logic [8:0] e;
    drive(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1);
    exp_q.push_back(V_NORMAL);
    #4;
    e = exp_q.pop_front();
    checks++;
    if (outs() !== e) begin
      errors++;
      $display("FAIL halt_entry: got %b want %b", outs(), e);
    end
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1, 5'd2, 5'd2, 5'd2, 1'(i & 1), 1'($urandom_range(0, 1)));
      exp_q.push_back(V_HALT);
      #4;
      e = exp_q.pop_front();
      checks++;
      if (outs() !== e) begin
        errors++;
        $display("FAIL halted[%0d]: got %b want %b", i, outs(), e);
      end
      tick();
    end
    nRST = 1'b0;
    exp_q.push_back(V_RST);
    #4;
    e = exp_q.pop_front();
    checks++;
    if (outs() !== e) begin
      errors++;
      $display("FAIL halt_reset: got %b want %b", outs(), e);
    end
    tick();
    nRST = 1'b1;
    idle();
    exp_q.push_back(V_NORMAL);
    #4;
    e = exp_q.pop_front();
    checks++;
    if (outs() !== e) begin
      errors++;
      $display("FAIL halt_exit_run: got %b want %b", outs(), e);
    end
    tick();
  endtask

  // Mixed random traffic checked against a behavioural priority model
  task automatic test_back_to_back();
    logic [8:0] e;
    logic ih, dh, drm, dwm, dre, br, lu;
    logic [4:0] ws, rs, rt;
    for (int i = 0; i < 40; i++) begin
      ih  = ($urandom_range(0, 3) != 0);
      dh  = 1'($urandom_range(0, 1));
      drm = ($urandom_range(0, 3) == 0);
      dwm = ($urandom_range(0, 5) == 0);
      dre = 1'($urandom_range(0, 1));
      br  = ($urandom_range(0, 4) == 0);
      ws  = 5'($urandom_range(0, 3));
      rs  = 5'($urandom_range(0, 3));
      rt  = 5'($urandom_range(0, 3));
      drive(ih, dh, drm, dwm, dre, ws, rs, rt, br, 0);
      lu = dre && (ws != 5'd0) && ((ws == rs) || (ws == rt));
      if ((drm || dwm) && !dh) exp_q.push_back(V_STALL);
      else if (br)             exp_q.push_back(V_BR);
      else if (lu)             exp_q.push_back(V_LU);
      else if (!ih)            exp_q.push_back(V_FMISS);
      else                     exp_q.push_back(V_NORMAL);
      #4;
      e = exp_q.pop_front();
      checks++;
      if (outs() !== e) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got %b want %b", i, outs(), e);
      end
      tick();
    end
    idle();
    tick();
  endtask

`ifdef PIPE_PERF_EN
  task automatic test_stall_counter();
    int unsigned model;
    nRST = 1'b0;
    idle();
    tick();
    nRST = 1'b1;
    checks++;
    if (stall_cycles !== 4'd0) begin
      errors++;
      $display("FAIL cnt_reset: got %0d want 0", stall_cycles);
    end
    model = 0;
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
      tick();
      if (model < 15) model++;
      if (i == 9 || i == 19) begin
        checks++;
        if (stall_cycles !== 4'(model)) begin
          errors++;
          $display("FAIL cnt_after_%0d: got %0d want %0d", i + 1, stall_cycles, model);
        end
      end
    end
    nRST = 1'b0;
    idle();
    tick();
    nRST = 1'b1;
    checks++;
    if (stall_cycles !== 4'd0) begin
      errors++;
      $display("FAIL cnt_cleared: got %0d want 0", stall_cycles);
    end
  endtask
`endif

  initial begin
    nRST = 1'b0;
    idle();
    tick();
    test_reset();
    test_load_use();
    test_mem_wait();
    test_branch_in_wait();
    test_branch_priority();
    test_reset_mid_wait();
    test_back_to_back();
    test_halt();
`ifdef PIPE_PERF_EN
    test_stall_counter();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
